// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one full-width ALU operation computed over WIDTH cycles on a 1-bit slice, LSB first.
// Latency: accept edge k, RUN edges k+1..k+WIDTH, done high the cycle after edge k+WIDTH, idle again after one more edge.
// Backpressure: ready only in IDLE; start outside IDLE is ignored, so start held high gives one op per WIDTH+2 cycles.

// One-bit ALU slice: full adder with optional B inversion, plus the bitwise logic functions.
module aluslice (
    input  logic [2:0] command,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       invtb,
    output logic       res,
    output logic       cout
);
    logic bb;
    logic sum;

    assign bb   = b ^ invtb;
    assign sum  = a ^ bb ^ cin;
    assign cout = (a & bb) | (a & cin) | (bb & cin);

    // Select the slice result; ADD, SUB and SLT all emit the sum bit.
    always_comb begin
        res = sum;
        case (command)
            3'b010:  res = a ^ b;
            3'b100:  res = a & b;
            3'b101:  res = ~(a & b);
            3'b110:  res = ~(a | b);
            3'b111:  res = a | b;
            default: res = sum;
        endcase
    end
endmodule

module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_SLT = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             carry_q, carry_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic             invtb;
    logic             slice_res;
    logic             slice_cout;
    logic             arith;
    logic             cmsb;
    logic             ovf;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] final_res;

    // Operands are shifted right each RUN cycle, so bit 0 is always the current bit.
    assign invtb = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    assign arith = (cmd_q == CMD_ADD) || invtb;
    assign cmsb  = carry_q;
    assign ovf   = slice_cout ^ cmsb;

    aluslice u_slice (
        .command (cmd_q),
        .a       (a_q[0]),
        .b       (b_q[0]),
        .cin     (carry_q),
        .invtb   (invtb),
        .res     (slice_res),
        .cout    (slice_cout)
    );

    // Next-state and datapath: latch on accept, step one bit per RUN cycle, publish flags on the last bit.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        cmd_d      = cmd_q;
        carry_d    = carry_q;
        acc_d      = acc_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        shifted    = {slice_res, acc_q};
        final_res  = shifted;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cmd_d   = command;
                    idx_d   = '0;
                    carry_d = (command == CMD_SUB) || (command == CMD_SLT);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = slice_cout;
                acc_d   = shifted[WIDTH-1:1];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(WIDTH - 1)) begin
                    // SLT replaces the difference with the true signed less-than bit.
                    if (cmd_q == CMD_SLT) begin
                        final_res    = '0;
                        final_res[0] = slice_res ^ ovf;
                    end
                    result_d   = final_res;
                    carryout_d = arith ? slice_cout : 1'b0;
                    overflow_d = arith ? ovf : 1'b0;
                    zero_d     = (final_res == '0);
                    idx_d      = '0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cmd_q      <= '0;
            carry_q    <= 1'b0;
            acc_q      <= '0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cmd_q      <= cmd_d;
            carry_q    <= carry_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer: computes one full-width ALU operation over WIDTH cycles by time-sharing a single 1-bit ALU slice (aluslice), LSB first.
- Latches operands, drives slice command, carry and invert-b each cycle, assembles the result, and produces carryout, overflow and zero flags.
- Low-area alternative to the WIDTH-slice ripple ALU; sits behind a start/ready/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted on a rising edge where start=1 and ready=1
command  input  3  000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ready  output  1  block idle, can accept start
done  output  1  one-cycle pulse: result and flags valid
result  output  WIDTH  operation result
carryout  output  1  carry out of MSB (ADD/SUB/SLT), else 0
overflow  output  1  signed overflow (ADD/SUB/SLT), else 0
zero  output  1  1 when result == 0

Behaviour:
- States: IDLE, RUN, DONE. ready = (state==IDLE), combinational from state. done = (state==DONE).
- Reset (sync, active-high): state=IDLE, bit index=0, result=0, carryout=0, overflow=0, zero=0, done=0; ready=1 from the first cycle after reset deasserts.
- Reset mid-RUN or in DONE: abort. Return to IDLE with all outputs cleared. No done pulse for the aborted operation.
- IDLE: on an accepting edge, latch a, b and command into internal shift registers, set index=0, carry=invtb, go to RUN. invtb=1 for SUB and SLT, else 0.
- RUN, one bit per edge:
  - Slice gets command, a[idx], b[idx], cin=carry and invtb. Slice zout is unused.
  - Slice result bit is shifted into the result register from the MSB side.
  - carry<=cout. On idx==WIDTH-1, also capture carry-in to the MSB (cmsb).
- Final RUN edge (idx==WIDTH-1):
  - ADD/SUB: carryout=cout, overflow=cout^cmsb.
  - SLT: result={WIDTH-1 zeros, sum_msb^overflow}; carryout and overflow reported as for SUB.
  - Logic ops: carryout=0, overflow=0.
  - zero = (final result == 0), computed on the final value, including the SLT fix-up.
  - State goes to DONE.
- Latency: accepting edge k; RUN occupies edges k+1..k+WIDTH; done=1 for exactly the one cycle after edge k+WIDTH. DONE->IDLE unconditionally at edge k+WIDTH+1.
- Back-to-back: start held high gives one accepted operation every WIDTH+2 cycles.
- start is ignored outside IDLE, including in DONE. a, b and command changes after acceptance have no effect.
- result and flags update only on the final RUN edge or reset. They hold their values through IDLE until the next operation completes; they are not cleared on accept.
- Arithmetic is modulo 2^WIDTH. SUB is a + ~b + 1.

Test Plan (WIDTH=8):
1. ADD a=8'h7F, b=8'h01 -> result 8'h80, carryout 0, overflow 1, zero 0. done high exactly in the 9th cycle after the accept edge (8 RUN edges, then DONE), for one cycle; ready returns the next cycle.
2. SUB a=8'h05, b=8'h05 -> result 8'h00, carryout 1, overflow 0, zero 1. SUB a=8'h00, b=8'h01 -> 8'hFF, carryout 0, zero 0.
3. SLT a=8'h80, b=8'h01 -> result 8'h01. SLT a=8'h7F, b=8'h80 (overflow case) -> result 8'h00, overflow 1. SLT a=8'h03, b=8'h03 -> 8'h00, zero 1.
4. Logic ops with a=8'hF0, b=8'h3C -> AND 8'h30, NAND 8'hCF, OR 8'hFC, XOR 8'hCC, NOR 8'h03; carryout=overflow=0. NOR with a=8'hF0, b=8'h0F -> 8'h00, zero 1.
5. Accept ADD 8'h10+8'h20, then during RUN pulse start and change a, b and command -> result 8'h30, no second operation. Start asserted during DONE is ignored.
6. Reset asserted after 3 RUN edges -> next cycle ready=1, result 0, all flags 0, no done pulse. A following ADD 8'h01+8'h01 completes correctly with result 8'h02. Start held high continuously -> accepts spaced WIDTH+2 cycles apart.
